// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use hazards, EX-stage redirects and data-memory waits.
// Enforces a data-memory timeout and a terminal HALTED state.
// Optional feature macro: PIPE_CTRL_PERF_EN enables the stall and flush
// performance counters. When it is undefined, both counter ports read
// zero and no counter flops are built.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_uses_rs1,
    input  logic        i_id_uses_rs2,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_ex_mem_read,
    input  logic        i_ex_redirect,
    input  logic        i_mem_req,
    input  logic        i_dmem_ready,
    input  logic        i_halt,
    output logic        o_pc_hold,
    output logic        o_ifid_stall,
    output logic        o_ifid_flush,
    output logic        o_idex_bubble,
    output logic        o_back_hold,
    output logic        o_mem_timeout,
    output logic        o_halted,
    output logic [31:0] o_stall_cycles,
    output logic [31:0] o_flush_count
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    // The timeout compare needs at least one MEM_WAIT cycle after entry.
    if (MEM_TIMEOUT < 2) begin : g_param_check
        $error("pipeline_ctrl: MEM_TIMEOUT must be >= 2");
    end

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic            mem_timeout_q, mem_timeout_d;

    logic            mem_stall;
    logic            load_use;

    assign mem_stall = i_mem_req & ~i_dmem_ready;
    assign load_use  = i_ex_mem_read & (i_ex_rd != 5'd0) &
                       ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                        (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));

    // State register, wait counter and sticky timeout flag.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Next-state logic: halt beats everything, ready beats timeout.
    // NOTE: every always_comb target gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        unique case (state_q)
            ST_RUN: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = CW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (i_halt) begin
                    state_d = ST_HALTED;
                end else if (!mem_stall) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == CNT_LAST) begin
                    state_d       = ST_HALTED;
                    mem_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Zero-latency control outputs from current state and current inputs.
    always_comb begin
        o_pc_hold     = 1'b0;
        o_ifid_stall  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_bubble = 1'b0;
        o_back_hold   = 1'b0;
        o_halted      = 1'b0;
        if (!i_rst) begin
            if (state_q == ST_HALTED) begin
                o_pc_hold    = 1'b1;
                o_ifid_stall = 1'b1;
                o_back_hold  = 1'b1;
                o_halted     = 1'b1;
            end else if (mem_stall) begin
                // The held EX instruction re-presents any redirect/load-use.
                o_pc_hold    = 1'b1;
                o_ifid_stall = 1'b1;
                o_back_hold  = 1'b1;
            end else if (i_ex_redirect) begin
                // ID holds a wrong-path instruction, so load-use is moot.
                o_ifid_flush  = 1'b1;
                o_idex_bubble = 1'b1;
            end else if (load_use) begin
                o_pc_hold     = 1'b1;
                o_ifid_stall  = 1'b1;
                o_idex_bubble = 1'b1;
            end
        end
    end

    assign o_mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    // Saturating performance counters for hold and flush cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (o_pc_hold && (state_q != ST_HALTED) && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (o_ifid_flush && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + 32'd1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_q;
    assign o_flush_count  = flush_count_q;
`else
    assign o_stall_cycles = 32'h0;
    assign o_flush_count  = 32'h0;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage RV32I pipeline. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB register banks and drives their stall, flush, bubble and hold controls. It resolves load-use hazards, EX-stage control-flow redirects and multi-cycle data-memory waits. It also enforces a data-memory timeout and a terminal halt state.

## Interface
Parameters:
- MEM_TIMEOUT, 16, total consecutive data-memory stall cycles tolerated before a timeout halt; must be ≥ 2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_id_rs1  in  5  source register 1 of the instruction in ID.
- i_id_rs2  in  5  source register 2 of the instruction in ID.
- i_id_uses_rs1  in  1  ID instruction reads rs1.
- i_id_uses_rs2  in  1  ID instruction reads rs2.
- i_ex_rd  in  5  destination register held in ID/EX.
- i_ex_mem_read  in  1  ID/EX holds a load.
- i_ex_redirect  in  1  EX resolved a taken branch, JAL or JALR.
- i_mem_req  in  1  MEM stage holds a valid load or store.
- i_dmem_ready  in  1  data memory completes the MEM-stage access this cycle.
- i_halt  in  1  WB is retiring a halting instruction (ebreak/trap).
- o_pc_hold  out  1  PC register keeps its value.
- o_ifid_stall  out  1  to IF/ID stall input.
- o_ifid_flush  out  1  to IF/ID flush input.
- o_idex_bubble  out  1  to ID/EX bubble input.
- o_back_hold  out  1  clock-enable-low for ID/EX, EX/MEM and MEM/WB; when asserted, all three hold.
- o_mem_timeout  out  1  sticky; the data-memory timeout fired.
- o_halted  out  1  controller is in HALTED.
- o_stall_cycles  out  32  performance counter (see Configuration).
- o_flush_count  out  32  performance counter (see Configuration).

## Operation
- States: RUN, MEM_WAIT, HALTED. A wait counter wait_cnt is $clog2(MEM_TIMEOUT+1) bits wide.
- Definitions:
  - mem_stall = i_mem_req & ~i_dmem_ready.
  - load_use = i_ex_mem_read & (i_ex_rd≠0) & ((i_id_uses_rs1 & i_id_rs1==i_ex_rd) | (i_id_uses_rs2 & i_id_rs2==i_ex_rd)).
- Output priority in RUN/MEM_WAIT, highest first:
  1. mem_stall: pc_hold=1, ifid_stall=1, back_hold=1, bubble=0, flush=0. A redirect or load-use in the same cycle is deferred, because the held EX instruction re-presents it.
  2. i_ex_redirect: ifid_flush=1, idex_bubble=1, pc_hold=0 (PC loads the target). Load-use is suppressed because the ID instruction is wrong-path.
  3. load_use: pc_hold=1, ifid_stall=1, idex_bubble=1. This gives a one-cycle stall; the next cycle sees the load in MEM and the hazard clears.
  4. Otherwise all control outputs are 0.
- HALTED: pc_hold=1, ifid_stall=1, back_hold=1, flush=0, bubble=0, o_halted=1. HALTED is left only by reset.
- Transitions, evaluated at the clock edge:
  - i_halt in RUN or MEM_WAIT → HALTED. This has highest priority.
  - RUN and mem_stall → MEM_WAIT, with wait_cnt←1.
  - MEM_WAIT and ~i_mem_req or i_dmem_ready → RUN, with wait_cnt←0.
  - MEM_WAIT and mem_stall and wait_cnt==MEM_TIMEOUT−1 → HALTED, with o_mem_timeout←1.
  - MEM_WAIT and mem_stall otherwise → wait_cnt←wait_cnt+1.
- A timeout halt occurs after exactly MEM_TIMEOUT consecutive mem_stall cycles.

## Timing
- All control outputs are combinational from the current state and the current-cycle inputs. There is zero latency: a hazard is acted on in the cycle it is presented.
- State, wait_cnt, o_mem_timeout and the counters are registered.
- While i_rst=1, all control outputs are forced to 0.
- After the reset edge: state=RUN, wait_cnt=0, o_mem_timeout=0, o_halted=0, o_stall_cycles=0, o_flush_count=0.
- Reset in the middle of MEM_WAIT or HALTED returns to RUN on that edge. No pending stall survives reset.
- If i_dmem_ready arrives in the same cycle that wait_cnt would time out, ready wins: no timeout, return to RUN.
- Back-to-back memory accesses: RUN→MEM_WAIT→RUN→MEM_WAIT restarts wait_cnt at 1 each time.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - o_stall_cycles increments each cycle o_pc_hold=1 in RUN or MEM_WAIT.
  - o_flush_count increments each cycle o_ifid_flush=1.
  - Both counters saturate at 32'hFFFF_FFFF.
- PIPE_CTRL_PERF_EN undefined: both ports are present and tied to 32'h0, and no counter flops are instantiated.

## Test plan
- Load-use: i_ex_mem_read=1, i_ex_rd=5, i_id_rs1=5, i_id_uses_rs1=1 → for one cycle pc_hold=1, ifid_stall=1, idex_bubble=1. With i_ex_rd=0 → no stall.
- Redirect plus load-use in the same cycle → ifid_flush=1, idex_bubble=1, pc_hold=0. With PERF, o_flush_count increments by 1.
- Memory wait: i_mem_req=1, i_dmem_ready=0 for 3 cycles, then 1 → back_hold=1 for 3 cycles, state returns to RUN, o_mem_timeout=0. With PERF, o_stall_cycles=3.
- Timeout: MEM_TIMEOUT=16, i_dmem_ready held 0 → o_mem_timeout and o_halted rise at the edge ending the 16th stall cycle. Ready arriving on the 16th cycle instead → no timeout.
- Halt: pulse i_halt in RUN → o_halted=1 and all holds asserted permanently, ignoring later redirect and load-use inputs, until i_rst.
- Reset mid-MEM_WAIT (wait_cnt=7) → next cycle state=RUN, outputs 0, o_mem_timeout=0.
